// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter: FSM state encoding,
// index-width and slice-offset helpers for the packed per-requester buses.
package rom_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

    // Index width for the default requester count of 4.
    localparam int NREQ_DEFAULT = 4;
    localparam int IDW          = idx_w(NREQ_DEFAULT);

endpackage

// File: rtl/rom_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo NREQ, returned as a onehot grant and as an index.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = IDW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one registered-read ROM port among NREQ requesters: round-robin burst
// grants, sequential (wrapping) address issue and tagged read-data return.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8,
    parameter int LW   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*LW-1:0]       req_len,
    output logic [NREQ-1:0]          req_ack,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_last,
    output logic                     busy,
    output logic                     rom_enable,
    output logic [AW-1:0]            rom_addr,
    input  logic [DW-1:0]            rom_data
);

    localparam int IDW_L = idx_w(NREQ);

    state_t             state;
    logic [IDW_L-1:0]   rr_ptr;
    logic [IDW_L-1:0]   owner;
    logic [LW-1:0]      beat_cnt;

    logic [NREQ-1:0]    pick_grant;
    logic [IDW_L-1:0]   pick_idx;
    logic               pick_any;
    logic [IDW_L-1:0]   next_ptr;
    logic [AW-1:0]      start_addr;
    logic [LW-1:0]      start_len;
    logic               last_issue;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW_L)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Onehot grant selects the winner's start address and length by OR-reduction.
    always_comb begin
        start_addr = '0;
        start_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                start_addr = start_addr | req_addr[slice_lo(i, AW) +: AW];
                start_len  = start_len  | req_len[slice_lo(i, LW) +: LW];
            end
        end
    end

    assign next_ptr   = (pick_idx == IDW_L'(NREQ - 1)) ? '0 : pick_idx + IDW_L'(1);
    assign last_issue = (state == BURST) && (beat_cnt == '0);
    assign rsp_data   = rom_data;
    assign busy       = (state == BURST) | rsp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            req_ack    <= '0;
            rom_enable <= 1'b0;
            rom_addr   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_last   <= 1'b0;
        end else begin
            // Response stage: the ROM registers the address issued last cycle,
            // so its tag and last flag trail the issue stage by one cycle.
            rsp_valid <= rom_enable;
            rsp_id    <= owner;
            rsp_last  <= rom_enable & last_issue;

            case (state)
                IDLE: begin
                    req_ack <= pick_grant;
                    if (pick_any) begin
                        owner      <= pick_idx;
                        rom_addr   <= start_addr;
                        rom_enable <= 1'b1;
                        beat_cnt   <= start_len;
                        rr_ptr     <= next_ptr;
                        state      <= BURST;
                    end else begin
                        rom_enable <= 1'b0;
                    end
                end
                BURST: begin
                    req_ack <= '0;
                    if (beat_cnt != '0) begin
                        rom_addr <= rom_addr + AW'(1);
                        beat_cnt <= beat_cnt - LW'(1);
                    end else begin
                        rom_enable <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level schedule of expected per-cycle outputs.
module tb_rom_burst_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int LW    = 2;
    localparam int IDW   = 2;
    localparam int DEPTH = 8192;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*LW-1:0]   req_len;
    logic [NREQ-1:0]      req_ack;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_last;
    logic                 busy;
    logic                 rom_enable;
    logic [AW-1:0]        rom_addr;
    logic [DW-1:0]        rom_data;
    logic [DW-1:0]        mem [16];

    rom_burst_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW),
        .LW   (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_ack    (req_ack),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .busy       (busy),
        .rom_enable (rom_enable),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_enable) rom_data <= mem[rom_addr];
    end

    // Expected outputs after edge n live at index n of these tables.
    int e_ack  [DEPTH];
    int e_vld  [DEPTH];
    int e_id   [DEPTH];
    int e_data [DEPTH];
    int e_last [DEPTH];
    int e_busy [DEPTH];
    int e_en   [DEPTH];
    int e_addr [DEPTH];

    int m_ptr;
    int m_free;
    int cyc;
    bit hold_all;
    bit rnd_on;
    int n_chk;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_from(input int c);
        for (int n = c; n < c + 16; n++) begin
            e_ack[n] = 0; e_vld[n] = 0; e_id[n] = 0; e_data[n] = 0;
            e_last[n] = 0; e_busy[n] = 0; e_en[n] = 0; e_addr[n] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("req_ack", 32'(req_ack), e_ack[cyc]);
        chk("rsp_valid", 32'(rsp_valid), e_vld[cyc]);
        chk("busy", 32'(busy), e_busy[cyc]);
        chk("rom_enable", 32'(rom_enable), e_en[cyc]);
        if (e_en[cyc] != 0) chk("rom_addr", 32'(rom_addr), e_addr[cyc]);
        if (e_vld[cyc] != 0) begin
            chk("rsp_id", 32'(rsp_id), e_id[cyc]);
            chk("rsp_data", 32'(rsp_data), e_data[cyc]);
            chk("rsp_last", 32'(rsp_last), e_last[cyc]);
        end
    endtask

    // Transaction model: when the port is free, the first requester found
    // from the pointer owns the next len+1 issue cycles; data trails by one.
    task automatic decide();
        int g, j, a, len;
        g = cyc + 1;
        if (rst && g >= m_free && req != '0) begin
            j = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (j < 0 && req[(m_ptr + k) % NREQ]) j = (m_ptr + k) % NREQ;
            end
            a   = int'(req_addr[j*AW +: AW]);
            len = int'(req_len[j*LW +: LW]);
            e_ack[g] = 1 << j;
            for (int b = 0; b <= len; b++) begin
                e_en[g+b]     = 1;
                e_addr[g+b]   = (a + b) % 16;
                e_vld[g+1+b]  = 1;
                e_id[g+1+b]   = j;
                e_data[g+1+b] = (a + b) % 16;
                e_last[g+1+b] = (b == len) ? 1 : 0;
            end
            for (int b = 0; b <= len + 1; b++) e_busy[g+b] = 1;
            m_ptr  = (j + 1) % NREQ;
            m_free = g + len + 2;
        end
    endtask

    task automatic random_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
                if ($urandom_range(3) == 0) begin
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_len[i*LW +: LW]  = LW'($urandom);
                    req[i] = 1'b1;
                end
            end else if ($urandom_range(39) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (!hold_all) begin
            for (int i = 0; i < NREQ; i++) if (e_ack[cyc][i]) req[i] = 1'b0;
        end
        if (rnd_on) random_stim();
        decide();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_req(input int i, input int a, input int len);
        req_addr[i*AW +: AW] = AW'(a);
        req_len[i*LW +: LW]  = LW'(len);
        req[i] = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(req_ack), 0);
        chk({tag, "_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_id"}, 32'(rsp_id), 0);
        chk({tag, "_last"}, 32'(rsp_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_enable"}, 32'(rom_enable), 0);
        chk({tag, "_addr"}, 32'(rom_addr), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        n_chk = 0; n_bad = 0; hold_all = 1'b0; rnd_on = 1'b0;
        m_ptr = 0; m_free = 0; cyc = 100;
        req = '0; req_addr = '0; req_len = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // All four requesting with len 0 and held: rotating grants.
        hold_all = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 4 * i + 1, 0);
        run(11);
        req = '0;
        hold_all = 1'b0;
        run(4);

        // Single-beat read and a wrapping four-beat burst.
        set_req(0, 3, 0);
        run(5);
        set_req(2, 14, 3);
        run(8);

        // Grant to 1, then 0 and 3 pending: pointer at 2 favours 3.
        set_req(1, 7, 1);
        run(1);
        set_req(0, 9, 0);
        set_req(3, 2, 2);
        run(12);

        // Short request raised and dropped during another burst.
        set_req(0, 8, 3);
        run(2);
        set_req(1, 5, 0);
        run(1);
        req[1] = 1'b0;
        run(8);

        // Reset in the middle of a four-beat burst.
        set_req(0, 5, 3);
        run(3);
        #1 rst = 1'b0;
        #1 check_all_zero("midrst");
        req = '0;
        clear_from(cyc);
        m_ptr = 0;
        m_free = 0;
        run(2);
        rst = 1'b1;
        run(4);

        // Random traffic.
        rnd_on = 1'b1;
        run(1500);
        rnd_on = 1'b0;
        req = '0;
        run(10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
